// File: rtl/code_defs_pkg.sv
// Shared type definitions for the receive-path frame buffer.
package code_defs_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } rx_buf_state_t;

   localparam int OB_ENTRIES = 2;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered 1-cycle read.
module sdp_ram #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 512
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rx_frame_buffer.sv
// Store-and-forward buffer after rx_mac: frames are released downstream only once their
// final beat reports a good CRC; bad or overflowing frames are discarded by rewinding wr_ptr.
module rx_frame_buffer
   import code_defs_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 512,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s00_axis_tkeep,
   input  logic                    s00_axis_tvalid,
   input  logic                    s00_axis_tlast,
   input  logic                    s00_axis_tuser,
   output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
   output logic                    m00_axis_tvalid,
   output logic                    m00_axis_tlast,
   input  logic                    m00_axis_tready,
   output logic [CNT_WIDTH-1:0]    o_frame_ok_count,
   output logic [CNT_WIDTH-1:0]    o_crc_err_count,
   output logic [CNT_WIDTH-1:0]    o_overflow_count
);

   localparam int DATA_NBYTES = DATA_WIDTH / 8;
   localparam int AW          = $clog2(DEPTH);
   localparam int RW          = DATA_WIDTH + DATA_NBYTES + 1;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic                 inc);
      if (inc && (cnt != '1)) return cnt + CNT_WIDTH'(1);
      return cnt;
   endfunction

   rx_buf_state_t          state, state_n;
   logic [AW-1:0]          wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr;
   logic                   stage_vld, stage_vld_n, stage_last, stage_last_n, stage_user, stage_user_n;
   logic [DATA_WIDTH-1:0]  stage_data, stage_data_n;
   logic [DATA_NBYTES-1:0] stage_keep, stage_keep_n;
   logic                   accepted, stage_open, full;
   logic                   ram_we, force_last;
   logic [RW-1:0]          ram_wdata;
   logic                   ok_inc, crc_inc, ovf_inc;

   assign accepted   = s00_axis_tvalid && ((s00_axis_tkeep != '0) || s00_axis_tlast);
   assign stage_open = stage_vld && !stage_last;
   assign full       = ((wr_ptr + AW'(1)) == rd_ptr);
   assign ram_wdata  = {stage_last | force_last, stage_keep, stage_data};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accepted && !s00_axis_tlast) state_n = WRITE;
         WRITE:   if (s00_axis_tvalid && s00_axis_tlast)  state_n = IDLE;
                  else if (accepted && stage_open && full) state_n = DROP;
         DROP:    if (s00_axis_tvalid && s00_axis_tlast)  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Write side: a held final beat is resolved first, then the incoming beat is applied.
   always_comb begin
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      stage_vld_n  = stage_vld;
      stage_last_n = stage_last;
      stage_user_n = stage_user;
      stage_data_n = stage_data;
      stage_keep_n = stage_keep;
      ram_we       = 1'b0;
      force_last   = 1'b0;
      ok_inc       = 1'b0;
      crc_inc      = 1'b0;
      ovf_inc      = 1'b0;
      if (stage_vld && stage_last) begin
         stage_vld_n  = 1'b0;
         stage_last_n = 1'b0;
         if (!stage_user) begin
            wr_ptr_n = commit_ptr;
            crc_inc  = 1'b1;
         end else if (full) begin
            wr_ptr_n = commit_ptr;
            ovf_inc  = 1'b1;
         end else begin
            ram_we       = 1'b1;
            wr_ptr_n     = wr_ptr + AW'(1);
            commit_ptr_n = wr_ptr + AW'(1);
            ok_inc       = 1'b1;
         end
      end
      if ((state != DROP) && accepted) begin
         if (s00_axis_tkeep != '0) begin
            if (stage_open && full) begin
               wr_ptr_n    = commit_ptr;
               stage_vld_n = 1'b0;
               ovf_inc     = 1'b1;
            end else begin
               if (stage_open) begin
                  ram_we   = 1'b1;
                  wr_ptr_n = wr_ptr + AW'(1);
               end
               stage_vld_n  = 1'b1;
               stage_last_n = s00_axis_tlast;
               stage_user_n = s00_axis_tuser;
               stage_data_n = s00_axis_tdata;
               stage_keep_n = s00_axis_tkeep;
            end
         end else if (stage_open) begin
            // Empty final beat: the staged beat becomes the last word of the frame.
            stage_vld_n = 1'b0;
            if (!s00_axis_tuser) begin
               wr_ptr_n = commit_ptr;
               crc_inc  = 1'b1;
            end else if (full) begin
               wr_ptr_n = commit_ptr;
               ovf_inc  = 1'b1;
            end else begin
               ram_we       = 1'b1;
               force_last   = 1'b1;
               wr_ptr_n     = wr_ptr + AW'(1);
               commit_ptr_n = wr_ptr + AW'(1);
               ok_inc       = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr           <= '0;
         commit_ptr       <= '0;
         stage_vld        <= 1'b0;
         stage_last       <= 1'b0;
         stage_user       <= 1'b0;
         o_frame_ok_count <= '0;
         o_crc_err_count  <= '0;
         o_overflow_count <= '0;
      end else begin
         wr_ptr           <= wr_ptr_n;
         commit_ptr       <= commit_ptr_n;
         stage_vld        <= stage_vld_n;
         stage_last       <= stage_last_n;
         stage_user       <= stage_user_n;
         o_frame_ok_count <= sat_inc(o_frame_ok_count, ok_inc);
         o_crc_err_count  <= sat_inc(o_crc_err_count, crc_inc);
         o_overflow_count <= sat_inc(o_overflow_count, ovf_inc);
      end
   end

   always_ff @(posedge i_clk) begin
      stage_data <= stage_data_n;
      stage_keep <= stage_keep_n;
   end

   // Read stage p0: issue a RAM read when the output buffer will have room on return.
   logic          rd_en_p0, rd_vld_p1, pop;
   logic [RW-1:0] ram_q_p1, ob_slot0, ob_slot1;
   logic [1:0]    ob_cnt;
   logic [2:0]    ob_level;

   assign pop      = (ob_cnt != 2'd0) && m00_axis_tready;
   assign ob_level = {1'b0, ob_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
   assign rd_en_p0 = (rd_ptr != commit_ptr) && (ob_level < 3'(OB_ENTRIES));

   sdp_ram #(.WIDTH(RW), .DEPTH(DEPTH)) u_ram (
      .clk     (i_clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr),
      .wr_data (ram_wdata),
      .rd_en   (rd_en_p0),
      .rd_addr (rd_ptr),
      .rd_data (ram_q_p1)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_ptr    <= '0;
         rd_vld_p1 <= 1'b0;
      end else begin
         rd_ptr    <= rd_ptr + AW'(rd_en_p0);
         rd_vld_p1 <= rd_en_p0;
      end
   end

   // Stage p1 -> output: two-entry buffer, slot0 always drives the AXIS master.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ob_cnt   <= 2'd0;
         ob_slot0 <= '0;
         ob_slot1 <= '0;
      end else begin
         case ({rd_vld_p1, pop})
            2'b10: begin
               if (ob_cnt == 2'd0) ob_slot0 <= ram_q_p1;
               else                ob_slot1 <= ram_q_p1;
               ob_cnt <= ob_cnt + 2'd1;
            end
            2'b01: begin
               ob_slot0 <= ob_slot1;
               ob_cnt   <= ob_cnt - 2'd1;
            end
            2'b11: begin
               if (ob_cnt == 2'd1) begin
                  ob_slot0 <= ram_q_p1;
               end else begin
                  ob_slot0 <= ob_slot1;
                  ob_slot1 <= ram_q_p1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m00_axis_tvalid = (ob_cnt != 2'd0);
   assign {m00_axis_tlast, m00_axis_tkeep, m00_axis_tdata} = ob_slot0;

endmodule
